// File: rtl/otter_pkg.sv
// rtl/otter_pkg.sv - shared types for the instruction fetch stage
package otter_pkg;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_JALR   = 2'b01,
        PC_BRANCH = 2'b10,
        PC_JAL    = 2'b11
    } pc_source_t;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sel_mux.sv
// rtl/pc_sel_mux.sv - next-pc select: sequential pc+4 or word-aligned redirect target
module pc_sel_mux
    import otter_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        redirect,
    input  logic [1:0]  pc_source,
    input  logic [31:0] jalr_target,
    input  logic [31:0] branch_target,
    input  logic [31:0] jal_target,
    output logic [31:0] next_pc
);

    logic [31:0] pc_plus4;

    always_comb begin
        pc_plus4 = pc + 32'd4;
        next_pc  = pc_plus4;
        // pc_source only matters while a redirect is being taken
        if (redirect) begin
            case (pc_source)
                PC_JALR:   next_pc = word_align(jalr_target);
                PC_BRANCH: next_pc = word_align(branch_target);
                PC_JAL:    next_pc = word_align(jal_target);
                default:   next_pc = pc_plus4;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with stall skid and flush, feeding the IF/DE register
module fetch_stage
    import otter_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        load_use_haz,
    input  logic        control_haz,
    input  logic [1:0]  pc_source,
    input  logic [31:0] jalr_target,
    input  logic [31:0] branch_target,
    input  logic [31:0] jal_target,
    output logic [31:0] imem_addr,
    output logic        imem_rden,
    input  logic [31:0] imem_data,
    output logic [31:0] de_pc,
    output logic [31:0] de_ir,
    output logic        de_valid
);

    logic [31:0]  pc;
    logic [31:0]  skid;
    logic [31:0]  next_pc;
    fetch_state_t state;

    pc_sel_mux u_pc_sel_mux (
        .pc            (pc),
        .redirect      (control_haz),
        .pc_source     (pc_source),
        .jalr_target   (jalr_target),
        .branch_target (branch_target),
        .jal_target    (jal_target),
        .next_pc       (next_pc)
    );

    assign imem_addr = pc;
    assign imem_rden = ~control_haz & ~load_use_haz;
    // memory output moves on once the stall cycle passes, so HOLD replays the captured word
    assign de_ir     = (state == HOLD) ? skid : imem_data;

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc       <= RESET_VEC;
            de_pc    <= 32'h0000_0000;
            de_valid <= 1'b0;
            skid     <= 32'h0000_0000;
            state    <= RUN;
        end else if (control_haz) begin
            pc       <= next_pc;
            de_valid <= 1'b0;
            state    <= RUN;
        end else if (load_use_haz) begin
            if (state == RUN) begin
                skid  <= imem_data;
                state <= HOLD;
            end
        end else begin
            de_pc    <= pc;
            de_valid <= 1'b1;
            pc       <= next_pc;
            state    <= RUN;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector table plus randomized run against a fetch model
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        load_use_haz = 1'b0;
    logic        control_haz = 1'b0;
    logic [1:0]  pc_source = 2'b00;
    logic [31:0] jalr_target = 32'h0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] jal_target = 32'h0;
    logic [31:0] imem_addr;
    logic        imem_rden;
    logic [31:0] imem_data = 32'h0;
    logic [31:0] de_pc;
    logic [31:0] de_ir;
    logic        de_valid;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage #(.RESET_VEC(32'h0000_0000)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .load_use_haz  (load_use_haz),
        .control_haz   (control_haz),
        .pc_source     (pc_source),
        .jalr_target   (jalr_target),
        .branch_target (branch_target),
        .jal_target    (jal_target),
        .imem_addr     (imem_addr),
        .imem_rden     (imem_rden),
        .imem_data     (imem_data),
        .de_pc         (de_pc),
        .de_ir         (de_ir),
        .de_valid      (de_valid)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0000_0008) return 32'h0000_2083;
        return a ^ 32'h1357_9BDF ^ {a[15:0], a[31:16]};
    endfunction

    always @(posedge CLK) if (imem_rden) imem_data <= word_at(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        rst;
        logic        lu;
        logic        ch;
        logic [1:0]  src;
        logic [31:0] tgt;
        logic [31:0] addr;
        logic        rden;
        logic        dv;
        logic [31:0] depc;
    } vec_t;

    function automatic vec_t mk(input string name, input logic rst, input logic lu, input logic ch,
                                input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] addr,
                                input logic rden, input logic dv, input logic [31:0] depc);
        vec_t v;
        v.name = name; v.rst = rst; v.lu = lu; v.ch = ch; v.src = src; v.tgt = tgt;
        v.addr = addr; v.rden = rden; v.dv = dv; v.depc = depc;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic lu, input logic ch,
                         input logic [1:0] src, input logic [31:0] tgt);
        RST = rst; load_use_haz = lu; control_haz = ch; pc_source = src;
        jalr_target   = (src == 2'b01) ? tgt : 32'hDEAD_0011;
        branch_target = (src == 2'b10) ? tgt : 32'hBEEF_0022;
        jal_target    = (src == 2'b11) ? tgt : 32'hCAFE_0033;
    endtask

    vec_t tv[$];

    logic [31:0] m_pc, m_depc, t_jalr, t_branch, t_jal;
    logic        m_dv, r_rst, r_lu, r_ch;
    logic [1:0]  r_src;

    initial begin
        tv.push_back(mk("run0",        0, 0, 0, 2'b00, 32'h0,         32'h0000_0000, 1, 0, 32'h0));
        tv.push_back(mk("run1",        0, 0, 0, 2'b00, 32'h0,         32'h0000_0004, 1, 1, 32'h0));
        tv.push_back(mk("run2",        0, 0, 0, 2'b00, 32'h0,         32'h0000_0008, 1, 1, 32'h4));
        tv.push_back(mk("stall",       0, 1, 0, 2'b00, 32'h0,         32'h0000_000C, 0, 1, 32'h8));
        tv.push_back(mk("stall_hold",  0, 0, 0, 2'b00, 32'h0,         32'h0000_000C, 1, 1, 32'h8));
        tv.push_back(mk("branch",      0, 0, 1, 2'b10, 32'h0000_0100, 32'h0000_0010, 0, 1, 32'hC));
        tv.push_back(mk("br_bubble",   0, 0, 0, 2'b00, 32'h0,         32'h0000_0100, 1, 0, 32'h0));
        tv.push_back(mk("both_haz",    0, 1, 1, 2'b01, 32'h0000_0203, 32'h0000_0104, 0, 1, 32'h100));
        tv.push_back(mk("jalr_bubble", 0, 0, 0, 2'b00, 32'h0,         32'h0000_0200, 1, 0, 32'h0));
        tv.push_back(mk("jalr_tgt",    0, 0, 0, 2'b00, 32'h0,         32'h0000_0204, 1, 1, 32'h200));
        tv.push_back(mk("jal_top",     0, 0, 1, 2'b11, 32'hFFFF_FFFF, 32'h0000_0208, 0, 1, 32'h204));
        tv.push_back(mk("top_bubble",  0, 0, 0, 2'b00, 32'h0,         32'hFFFF_FFFC, 1, 0, 32'h0));
        tv.push_back(mk("wrap",        0, 0, 0, 2'b00, 32'h0,         32'h0000_0000, 1, 1, 32'hFFFF_FFFC));
        tv.push_back(mk("flush_plus4", 0, 0, 1, 2'b00, 32'h0,         32'h0000_0004, 0, 1, 32'h0));
        tv.push_back(mk("p4_stall",    0, 1, 0, 2'b00, 32'h0,         32'h0000_0008, 0, 0, 32'h0));
        tv.push_back(mk("hold_stall",  0, 1, 0, 2'b00, 32'h0,         32'h0000_0008, 0, 0, 32'h0));
        tv.push_back(mk("rst_in_hold", 1, 1, 0, 2'b00, 32'h0,         32'h0000_0008, 0, 0, 32'h0));
        tv.push_back(mk("post_rst",    0, 0, 0, 2'b00, 32'h0,         32'h0000_0000, 1, 0, 32'h0));
        tv.push_back(mk("post_rst_de", 0, 0, 0, 2'b00, 32'h0,         32'h0000_0004, 1, 1, 32'h0));

        drive(1, 0, 0, 2'b00, 32'h0);
        @(posedge CLK); #1;
        foreach (tv[i]) begin
            drive(tv[i].rst, tv[i].lu, tv[i].ch, tv[i].src, tv[i].tgt);
            #3;
            check({tv[i].name, ".addr"}, imem_addr, tv[i].addr);
            check({tv[i].name, ".rden"}, {31'b0, imem_rden}, {31'b0, tv[i].rden});
            check({tv[i].name, ".valid"}, {31'b0, de_valid}, {31'b0, tv[i].dv});
            if (tv[i].dv) begin
                check({tv[i].name, ".de_pc"}, de_pc, tv[i].depc);
                check({tv[i].name, ".de_ir"}, de_ir, word_at(tv[i].depc));
            end
            @(posedge CLK); #1;
        end

        drive(1, 0, 0, 2'b00, 32'h0);
        @(posedge CLK); #1;
        m_pc = 32'h0; m_depc = 32'h0; m_dv = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            r_rst = ($urandom_range(99) < 3);
            r_lu  = ($urandom_range(99) < 30);
            r_ch  = ($urandom_range(99) < 15);
            r_src = 2'($urandom_range(3));
            t_jalr   = $urandom;
            t_branch = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(15)) : $urandom;
            t_jal    = $urandom;
            RST = r_rst; load_use_haz = r_lu; control_haz = r_ch; pc_source = r_src;
            jalr_target = t_jalr; branch_target = t_branch; jal_target = t_jal;
            #3;
            check("rnd.addr", imem_addr, m_pc);
            check("rnd.rden", {31'b0, imem_rden}, {31'b0, ~r_ch & ~r_lu});
            check("rnd.valid", {31'b0, de_valid}, {31'b0, m_dv});
            if (m_dv) begin
                check("rnd.de_pc", de_pc, m_depc);
                check("rnd.de_ir", de_ir, word_at(m_depc));
            end
            @(posedge CLK);
            if (r_rst) begin
                m_pc = 32'h0; m_dv = 1'b0;
            end else if (r_ch) begin
                case (r_src)
                    2'b01:   m_pc = t_jalr & ~32'd3;
                    2'b10:   m_pc = t_branch & ~32'd3;
                    2'b11:   m_pc = t_jal & ~32'd3;
                    default: m_pc = m_pc + 32'd4;
                endcase
                m_dv = 1'b0;
            end else if (!r_lu) begin
                m_depc = m_pc; m_dv = 1'b1; m_pc = m_pc + 32'd4;
            end
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
